// File: rtl/led_fade_driver.sv
// LED fade driver: a lit input channel goes to full brightness, and after release
// it fades out through a PWM level that steps down once per decay period.
module led_fade_driver #(
  parameter int CH       = 3,
  parameter int PRESCALE = 49_999,
  parameter int DECAY_MS = 20,
  parameter int PWM_BITS = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CH-1:0] LED_In,
  input  logic          Enable,
  output logic [CH-1:0] LED_Out,
  output logic          Busy
);

  localparam int MAX_LEVEL = 2**PWM_BITS - 1;
  localparam int PS_W      = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int MS_W      = (DECAY_MS > 1) ? $clog2(DECAY_MS) : 1;

  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE);
  localparam logic [MS_W-1:0]     MS_LAST  = MS_W'(DECAY_MS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = PWM_BITS'(MAX_LEVEL);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX_LEVEL - 1);

  // Brightness decrement that sticks at zero instead of wrapping.
  function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] lvl);
    return (lvl == '0) ? lvl : lvl - PWM_BITS'(1);
  endfunction

  logic [PS_W-1:0]                  pre_cnt;
  logic [MS_W-1:0]                  ms_cnt;
  logic [PWM_BITS-1:0]              pwm_cnt;
  logic                             tick;
  logic                             decay_stb;
  logic [CH-1:0]                    in_p0;
  logic [CH-1:0][PWM_BITS-1:0]      lvl_p1;

  assign tick      = (pre_cnt == PS_LAST);
  assign decay_stb = tick && (ms_cnt == MS_LAST);

  // Timebase: 1 ms prescaler, decay-period counter, free-running PWM ramp.
  always_ff @(posedge CLK) begin
    if (RST || !Enable) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PS_W'(1);
      if (tick) begin
        ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + MS_W'(1);
      end
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
    end
  end

  // Stage p0: register the incoming pattern; keeps running while disabled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_p0 <= '0;
    end else begin
      in_p0 <= LED_In;
    end
  end

  // Stage p1 -> p2: per-channel level update, then PWM compare into the pins.
  always_ff @(posedge CLK) begin
    if (RST || !Enable) begin
      lvl_p1  <= '0;
      LED_Out <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (in_p0[i]) begin
          lvl_p1[i] <= LVL_MAX;
        end else if (decay_stb) begin
          lvl_p1[i] <= sat_dec(lvl_p1[i]);
        end
        LED_Out[i] <= (lvl_p1[i] > pwm_cnt);
      end
    end
  end

  assign Busy = |lvl_p1;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with a short timebase (decay strobe every 8 cycles).
module tb_led_fade_driver;

  localparam int CH       = 3;
  localparam int PRESCALE = 3;
  localparam int DECAY_MS = 2;
  localparam int PWM_BITS = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Enable = 1'b1;
  logic [CH-1:0] LED_In = '0;
  logic [CH-1:0] LED_Out;
  logic          Busy;

  int checks = 0;
  int errors = 0;

  led_fade_driver #(
    .CH(CH), .PRESCALE(PRESCALE), .DECAY_MS(DECAY_MS), .PWM_BITS(PWM_BITS)
  ) dut (
    .CLK(CLK), .RST(RST), .LED_In(LED_In), .Enable(Enable),
    .LED_Out(LED_Out), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Input schedule per phase: value sampled at edge m after reset release.
  function automatic bit in_at(input int ph, input int m);
    if (ph == 0) return (m >= 2 && m <= 30) || m == 151 || m == 152 || m == 223;
    return (m == 1 || m == 2);
  endfunction

  // Hand-derived level of the active channel after edge n (strobes at n = 8k).
  function automatic int lvl_at(input int ph, input int n);
    if (ph == 0) begin
      if (n < 3)   return 0;
      if (n < 32)  return 15;
      if (n < 144) return 14 - (n - 32) / 8;
      if (n < 152) return 0;
      if (n < 160) return 15;
      if (n < 224) return 14 - (n - 160) / 8;
      if (n < 232) return 15;
      return 14 - (n - 232) / 8;
    end
    if (n < 2)    return 0;
    if (n < 8)    return 15;
    if (n <= 120) return 15 - n / 8;
    return 0;
  endfunction

  task automatic run_phase(input int ph, input int ch, input int nmax);
    logic [CH-1:0] mask;
    logic [CH-1:0] exp_out;
    mask = CH'(1 << ch);
    for (int n = 1; n <= nmax; n++) begin
      LED_In = in_at(ph, n) ? mask : '0;
      step();
      exp_out = (lvl_at(ph, n - 1) > ((n - 1) % 15)) ? mask : '0;
      chk($sformatf("ph%0d_out_n%0d", ph, n), 32'(LED_Out), 32'(exp_out));
      chk($sformatf("ph%0d_busy_n%0d", ph, n), 32'(Busy), 32'(lvl_at(ph, n) != 0));
    end
  endtask

  initial begin
    // Reset held with all inputs lit.
    RST = 1'b1;
    LED_In = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_out_%0d", i), 32'(LED_Out), 32'd0);
      chk($sformatf("rst_busy_%0d", i), 32'(Busy), 32'd0);
    end
    RST = 1'b0;

    // Light ch0, release and fade, retrigger, then retrigger on a decay strobe edge.
    run_phase(0, 0, 240);

    // Enable drop clears everything; relight only via new input.
    LED_In = 3'b111;
    step();
    step();
    chk("en_busy_lit", 32'(Busy), 32'd1);
    step();
    chk("en_out_lit", 32'(LED_Out), 32'h7);
    Enable = 1'b0;
    LED_In = 3'b000;
    step();
    chk("en_off_out", 32'(LED_Out), 32'd0);
    chk("en_off_busy", 32'(Busy), 32'd0);
    Enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("en_dark_out_%0d", i), 32'(LED_Out), 32'd0);
      chk($sformatf("en_dark_busy_%0d", i), 32'(Busy), 32'd0);
    end
    LED_In = 3'b010;
    step();
    chk("en_relight_out_e1", 32'(LED_Out), 32'd0);
    step();
    chk("en_relight_busy", 32'(Busy), 32'd1);
    step();
    chk("en_relight_out_e3", 32'(LED_Out), 32'h2);
    step();
    chk("en_relight_out_e4", 32'(LED_Out), 32'h2);

    // Mid-fade reset, then check decay phase restarts with the counters.
    LED_In = 3'b111;
    step();
    step();
    step();
    chk("rst6_out_lit", 32'(LED_Out), 32'h7);
    LED_In = 3'b000;
    for (int i = 0; i < 10; i++) step();
    chk("rst6_busy_midfade", 32'(Busy), 32'd1);
    RST = 1'b1;
    step();
    chk("rst6_out_cleared", 32'(LED_Out), 32'd0);
    chk("rst6_busy_cleared", 32'(Busy), 32'd0);
    RST = 1'b0;
    run_phase(1, 2, 125);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
